// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: streams in ifmap, weights and bias, runs
// LANES neurons per tile and emits int8-requantised or raw int32 results.
// Ports: clk/rst (sync, active-high); start + cfg_* job setup;
// ld_valid/ld_ready/ld_data load stream; out_valid/out_ready/out_data/
// out_last result stream; busy, done pulse, err pulse on bad config.
module mlp_layer_engine #(
  parameter int LANES   = 8,
  parameter int MAX_IN  = 64,
  parameter int MAX_OUT = 64,
  parameter int SCALE_W = 12,
  parameter int SHIFT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_IN):0]    cfg_in_dim,
  input  logic [$clog2(MAX_OUT):0]   cfg_out_dim,
  input  logic                       cfg_mode,
  input  logic [SCALE_W-1:0]         cfg_scale,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [31:0]                ld_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int IW    = $clog2(MAX_IN) + 1;
  localparam int OW    = $clog2(MAX_OUT) + 1;
  localparam int XW    = MAX_IN / 4;
  localparam int XC    = $clog2(XW);
  localparam int KW    = $clog2(MAX_IN);
  localparam int NT    = (MAX_OUT + LANES - 1) / LANES;
  localparam int WROWS = NT * LANES;
  localparam int WR    = $clog2(WROWS);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [47:0] RND = 48'd1 << (SHIFT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_REQ, S_DRAIN, S_FIN
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      in_q;
  logic [OW-1:0]      out_q;
  logic               mode_q;
  logic [SCALE_W-1:0] scale_q;
  logic [1:0]         ph_q;
  logic [XC-1:0]      col_q;
  logic [WR-1:0]      row_q;
  logic [KW-1:0]      k_q;
  logic [WR-1:0]      nb_q;
  logic [LW-1:0]      d_q;
  logic               ld_ready_q;
  logic               out_valid_q;
  logic [31:0]        out_data_q;
  logic               out_last_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [31:0] x_mem [XW];
  logic [31:0] w_mem [WROWS][XW];
  logic [31:0] b_mem [WROWS];
  logic [31:0] acc_q [LANES];
  logic [31:0] acc_d [LANES];
  logic [31:0] res_q [LANES];

  logic          ld_acc;
  logic          cfg_ok;
  logic [IW-1:0] nw;
  logic          col_last;
  logic          row_last;
  logic [LW-1:0] d_nx;

  assign ld_ready  = ld_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  assign ld_acc = ld_valid && ld_ready_q;
  assign cfg_ok = (cfg_in_dim >= IW'(4))
               && (cfg_in_dim <= IW'(MAX_IN))
               && (cfg_in_dim[1:0] == 2'b00)
               && (cfg_out_dim != '0)
               && (cfg_out_dim <= OW'(MAX_OUT));
  assign nw       = in_q >> 2;
  assign col_last = int'(col_q) == int'(nw) - 1;
  assign row_last = int'(row_q) == int'(out_q) - 1;
  assign d_nx     = d_q + LW'(1);

  // p is wide enough that acc*scale never overflows before the shift.
  function automatic logic [31:0] requant(
    input logic [31:0]        a,
    input logic [SCALE_W-1:0] s,
    input logic               raw
  );
    logic signed [47:0] p;
    logic signed [47:0] r;
    logic [7:0]         y;
    p = $signed({{16{a[31]}}, a})
      * $signed({{(48-SCALE_W){1'b0}}, s});
    r = $signed(p + RND) >>> SHIFT;
    if (r < 0)
      y = 8'd0;
    else if (r > 48'sd127)
      y = 8'd127;
    else
      y = r[7:0];
    return raw ? a : {24'd0, y};
  endfunction

  always_ff @(posedge clk) begin
    if (ld_acc) begin
      case (ph_q)
        2'd0:    x_mem[col_q] <= ld_data;
        2'd1:    w_mem[row_q][col_q] <= ld_data;
        default: b_mem[row_q] <= ld_data;
      endcase
    end
  end

  // Lane l works on neuron nb_q+l; the first step seeds with bias.
  always_comb begin
    logic [WR-1:0]      row;
    logic [XC-1:0]      kc;
    logic [4:0]         bo;
    logic [7:0]         xb;
    logic [7:0]         wb;
    logic signed [15:0] prod;
    logic [31:0]        base;
    row  = '0;
    kc   = k_q[KW-1:2];
    bo   = {k_q[1:0], 3'b000};
    xb   = x_mem[kc][bo +: 8];
    wb   = '0;
    prod = '0;
    base = '0;
    for (int l = 0; l < LANES; l++) begin
      row      = nb_q + WR'(l);
      wb       = w_mem[row][kc][bo +: 8];
      prod     = $signed(xb) * $signed(wb);
      base     = (k_q == '0) ? b_mem[row] : acc_q[l];
      acc_d[l] = base + {{16{prod[15]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_MAC)
      acc_q <= acc_d;
    if (state_q == S_REQ)
      for (int l = 0; l < LANES; l++)
        res_q[l] <= requant(acc_q[l], scale_q, mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_q        <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      scale_q     <= '0;
      ph_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      k_q         <= '0;
      nb_q        <= '0;
      d_q         <= '0;
      ld_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            in_q    <= cfg_in_dim;
            out_q   <= cfg_out_dim;
            mode_q  <= cfg_mode;
            scale_q <= cfg_scale;
            if (cfg_ok) begin
              state_q    <= S_LOAD;
              busy_q     <= 1'b1;
              ld_ready_q <= 1'b1;
              ph_q       <= '0;
              col_q      <= '0;
              row_q      <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_acc) begin
            case (ph_q)
              2'd0: begin
                if (col_last) begin
                  ph_q  <= 2'd1;
                  col_q <= '0;
                end else begin
                  col_q <= col_q + XC'(1);
                end
              end
              2'd1: begin
                if (col_last) begin
                  col_q <= '0;
                  if (row_last) begin
                    ph_q  <= 2'd2;
                    row_q <= '0;
                  end else begin
                    row_q <= row_q + WR'(1);
                  end
                end else begin
                  col_q <= col_q + XC'(1);
                end
              end
              default: begin
                if (row_last) begin
                  state_q    <= S_MAC;
                  ld_ready_q <= 1'b0;
                  k_q        <= '0;
                  nb_q       <= '0;
                end else begin
                  row_q <= row_q + WR'(1);
                end
              end
            endcase
          end
        end
        S_MAC: begin
          if (int'(k_q) == int'(in_q) - 1)
            state_q <= S_REQ;
          else
            k_q <= k_q + KW'(1);
        end
        S_REQ: begin
          // Lane 0 goes straight to the port so the first beat is
          // visible on the first DRAIN cycle.
          state_q     <= S_DRAIN;
          d_q         <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= requant(acc_q[0], scale_q, mode_q);
          out_last_q  <= int'(nb_q) == int'(out_q) - 1;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (int'(d_q) == LANES - 1 ||
                int'(nb_q) + int'(d_q) == int'(out_q) - 1) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (int'(nb_q) + LANES < int'(out_q)) begin
                state_q <= S_MAC;
                nb_q    <= nb_q + WR'(LANES);
                k_q     <= '0;
              end else begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end
            end else begin
              d_q        <= d_nx;
              out_data_q <= res_q[d_nx];
              out_last_q <= int'(nb_q) + int'(d_nx)
                            == int'(out_q) - 1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mlp_layer_engine.md
# mlp_layer_engine

Parametrised single-layer MLP engine: the successor to the fixed 8x8 int8 array top. It accepts a configurable fully-connected layer with `IN_DIM`≤`MAX_IN` and `OUT_DIM`≤`MAX_OUT`. It loads ifmap, weights and bias over one streaming port, computes `LANES` output neurons in parallel per tile, and emits results one per beat on a valid/ready port. Each result is either requantised int8 (ReLU, rounding, saturation) or raw int32. It sits between the DRAM loader and the output writeback in the accelerator.

## Interface
Parameters:
- `LANES`, 8: parallel MAC lanes (output neurons per tile).
- `MAX_IN`, 64: maximum input dimension; a multiple of 4.
- `MAX_OUT`, 64: maximum output dimension.
- `SCALE_W`, 12: requant scale width (unsigned).
- `SHIFT`, 8: requant right shift; ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: job start pulse; sampled in IDLE only.
- `cfg_in_dim` in $clog2(MAX_IN)+1: input length.
- `cfg_out_dim` in $clog2(MAX_OUT)+1: output length.
- `cfg_mode` in 1: 0 = int8 requant+ReLU; 1 = raw int32.
- `cfg_scale` in SCALE_W: requant multiplier.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 32: load stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_last` out 1: result stream.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: one-cycle pulse when `start` carries an invalid config.

## Operation
- States: IDLE, LOAD, MAC, REQ, DRAIN, FIN.
- IDLE: on `start`, latch all cfg signals.
  - Config is valid iff `cfg_in_dim` is in 4..MAX_IN, `cfg_in_dim` is a multiple of 4, and `cfg_out_dim` is in 1..MAX_OUT.
  - Valid config -> LOAD.
  - Invalid config -> `err`=1 for one cycle; stay in IDLE.
- LOAD: `ld_ready`=1; a word is accepted on `ld_valid&&ld_ready`. Words arrive in fixed order:
  - ifmap: `in/4` words; byte b of word j = x[4j+b], signed int8.
  - weights: `out*(in/4)` words, row-major; word `o*(in/4)+j` byte b = W[o][4j+b], signed int8.
  - bias: `out` words, signed int32.
  - After the last bias word -> MAC, tile t=0.
- MAC: `in` cycles, k = 0..in-1.
  - Each lane l computes neuron n=t*LANES+l.
  - At k=0, the accumulator is loaded with bias[n] + x[0]*W[n][0].
  - Every later cycle: acc += x[k]*W[n][k].
  - 8x8 signed products, sign-extended; int32 accumulation wraps mod 2^32.
  - Lanes with n≥out compute don't-care values.
- REQ (1 cycle): register the result per lane.
  - Raw mode: result = acc.
  - Requant mode:
    - p = acc*scale, computed as signed 48-bit.
    - r = (p + 2^(SHIFT-1)) >>> SHIFT.
    - y = clamp(r, 0, 127).
    - result = {24'd0, y[7:0]}.
- DRAIN: present lane 0 upward, one per accepted beat, for lanes with n<out only.
  - `out_last`=1 on neuron out-1.
  - After the last lane of a tile: more tiles -> MAC with t+1; otherwise -> FIN.
- FIN: `done`=1 for one cycle -> IDLE.
- Weight storage must allow LANES parallel reads per cycle; register-array implementation is acceptable.
- Loaded data persists only for the current job; every job reloads all three regions.

## Timing
- Reset: state=IDLE; `ld_ready`, `out_valid`, `out_last`, `busy`, `done`, `err` = 0; `out_data` = 0.
- `rst` in any state returns to IDLE on the next edge. No partial output follows. Memory contents are don't-care.
- `busy`=1 from the cycle after an accepted `start` through FIN inclusive.
- `start` while `busy` is ignored.
- `ld_ready`=1 only in LOAD; words offered outside LOAD are not consumed.
- Output handshake:
  - `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
  - `out_valid` never deasserts without a transfer.
  - With `out_ready` held high, consecutive beats are back-to-back.
- Per tile: `in` MAC cycles + 1 REQ cycle + min(LANES, out-t*LANES) DRAIN beats.
- First `out_valid` appears in-th+2 cycle after the last load word is accepted.
- `done` asserts the cycle after the final beat transfers.
- `err` and `done` never coincide.

## Test plan
- in=4, out=1, raw; x={1,2,3,4}, W={1,1,1,1}, bias=10 -> one beat `out_data`=20, `out_last`=1; `done` next cycle.
- Requant, scale=128, SHIFT=8:
  - acc=100 -> 50.
  - acc=-50 -> 0.
  - acc=1000 with scale=256 -> 127.
  - acc=1 with scale=128 -> 1 (rounding half up).
- Saturation extreme: in=64, raw, all x=-128, W=-128, bias=0 -> each output 1048576.
- out=10, LANES=8, raw, W[o][k]=o, x=1, in=4, bias=0 -> 10 beats with values 0,4,…,36; `out_last` only on the 10th beat.
- Backpressure: drop `out_ready` for 5 cycles mid-drain -> data held stable; no beat duplicated or lost; sequence identical to the no-stall run.
- `start` with in=6 -> `err` pulse, `busy`=0, `ld_ready`=0.
- `rst` mid-MAC -> next cycle `busy`=0, `out_valid`=0; a following valid job matches the reference model.
